// File: rtl/st4_mem_access_unit_if.sv
// Request/response and data-memory bundle for the MEM-stage access unit.
// master: the access unit; slave: pipeline plus memory side.
interface st4_mem_access_unit_if #(
  parameter int ADDR_W = 16,
  parameter int MEM_AW = 15,
  parameter int DATA_W = 16
);
  // pipeline request / response
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_mem_read;
  logic [1:0]        req_mem_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              resp_err;
  // data memory port
  logic              mem_re;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  req_valid,
    output req_ready,
    input  req_mem_read,
    input  req_mem_write,
    input  req_addr,
    input  req_wdata,
    output resp_valid,
    output resp_data,
    output resp_err,
    output mem_re,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    output req_valid,
    input  req_ready,
    output req_mem_read,
    output req_mem_write,
    output req_addr,
    output req_wdata,
    input  resp_valid,
    input  resp_data,
    input  resp_err,
    input  mem_re,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/st4_mem_access_unit.sv
// MEM-stage load/store initiator for a 16-bit-word data memory.
// Ports: clk, rst (sync, active-high), bus (st4_mem_access_unit_if.master).
module st4_mem_access_unit #(
  parameter int ADDR_W = 16,
  parameter int MEM_AW = 15,
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  st4_mem_access_unit_if.master bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD      = 3'd1;
  localparam logic [2:0] S_RD_WAIT = 3'd2;
  localparam logic [2:0] S_WR      = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;

  // OP_LW is zero so cleared registers select a plain word path
  localparam logic [1:0] OP_LW  = 2'd0;
  localparam logic [1:0] OP_LBU = 2'd1;
  localparam logic [1:0] OP_SW  = 2'd2;
  localparam logic [1:0] OP_SB  = 2'd3;

  logic [2:0]        r_state;
  logic [1:0]        r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_word;
  logic [DATA_W-1:0] r_resp_data;
  logic              r_resp_err;

  logic              w_none;
  logic              w_illegal;
  logic              w_err;
  logic [1:0]        w_op;
  logic              w_a0;
  logic [7:0]        w_lane;
  logic [DATA_W-1:0] w_sb_word;
  logic [MEM_AW-1:0] w_mem_addr;

  assign w_a0 = bus.req_addr[0];

  assign w_none =
    (bus.req_mem_read == 2'b00) &&
    (bus.req_mem_write == 2'b00);

  assign w_illegal =
    ((bus.req_mem_read != 2'b00) &&
     (bus.req_mem_write != 2'b00)) ||
    (bus.req_mem_read == 2'b11) ||
    (bus.req_mem_write == 2'b11);

  always_comb begin
    w_err = 1'b0;
    w_op  = OP_LW;
    unique case (1'b1)
      w_none: begin
        w_err = 1'b0;
      end
      w_illegal: begin
        w_err = 1'b1;
      end
      (!w_illegal && bus.req_mem_read == 2'b01): begin
        w_op  = OP_LW;
        w_err = w_a0;
      end
      (!w_illegal && bus.req_mem_read == 2'b10): begin
        w_op  = OP_LBU;
      end
      (!w_illegal && bus.req_mem_write == 2'b01): begin
        w_op  = OP_SW;
        w_err = w_a0;
      end
      (!w_illegal && bus.req_mem_write == 2'b10): begin
        w_op  = OP_SB;
      end
      default: begin
        w_err = 1'b0;
      end
    endcase
  end

  // lane of the word arriving from memory in RD_WAIT
  assign w_lane = r_addr[0] ?
    bus.mem_rdata[15:8] : bus.mem_rdata[7:0];

  // store-byte merge: replace one lane, keep the other
  assign w_sb_word = r_addr[0] ?
    {r_wdata[7:0], r_word[7:0]} :
    {r_word[15:8], r_wdata[7:0]};

  assign w_mem_addr = r_addr[ADDR_W-1:1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_op        <= OP_LW;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_word      <= '0;
      r_resp_data <= '0;
      r_resp_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid && !w_none) begin
            r_op    <= w_op;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
            if (w_err) begin
              r_resp_data <= '0;
              r_resp_err  <= 1'b1;
              r_state     <= S_RESP;
            end else if (w_op == OP_SW) begin
              r_state <= S_WR;
            end else begin
              r_state <= S_RD;
            end
          end
        end
        S_RD: begin
          r_state <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          r_word <= bus.mem_rdata;
          if (r_op == OP_SB) begin
            r_state <= S_WR;
          end else begin
            r_resp_data <= (r_op == OP_LW) ?
              bus.mem_rdata : {8'h00, w_lane};
            r_resp_err  <= 1'b0;
            r_state     <= S_RESP;
          end
        end
        S_WR: begin
          r_resp_data <= '0;
          r_resp_err  <= 1'b0;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = (r_state == S_IDLE);
  assign bus.resp_valid = (r_state == S_RESP);
  assign bus.resp_data  = r_resp_data;
  assign bus.resp_err   = r_resp_err;

  // enables gated by rst so an aborted write never reaches memory
  assign bus.mem_re = !rst && (r_state == S_RD);
  assign bus.mem_we = !rst && (r_state == S_WR);

  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_wdata = (r_op == OP_SB) ?
    w_sb_word : r_wdata;

endmodule

// File: tb/tb_st4_mem_access_unit.sv
// Randomized and directed bench for st4_mem_access_unit.
// Reference model computes expected latency/data from memory contents.
module tb_st4_mem_access_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  st4_mem_access_unit_if ifc ();

  st4_mem_access_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  logic [15:0] phys [0:32767];
  logic [15:0] refm [0:32767];

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] prev_data;
  logic        prev_err;

  // synchronous memory: read data the cycle after mem_re
  always @(posedge clk) begin
    if (ifc.mem_re) ifc.mem_rdata <= phys[ifc.mem_addr];
    if (ifc.mem_we) phys[ifc.mem_addr] = ifc.mem_wdata;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic set_word(input logic [14:0] w,
                          input logic [15:0] v);
    phys[w] = v;
    refm[w] = v;
  endtask

  task automatic run_req(input logic [1:0] rd,
                         input logic [1:0] wr,
                         input logic [15:0] a,
                         input logic [15:0] wd,
                         input bit pulse);
    logic [14:0] w;
    bit ln, noop, err;
    int e_resp, e_re, e_we;
    logic [15:0] e_data, e_wd, old;
    int n_re, n_we, n_resp, c_re, c_we, c_resp;
    int both, busy_bad;
    logic [14:0] a_re, a_we;
    logic [15:0] d_we, r_d;
    logic r_e;

    w    = a[15:1];
    ln   = a[0];
    noop = (rd == 2'd0) && (wr == 2'd0);
    err  = !noop && ((rd != 0 && wr != 0) ||
           rd == 2'd3 || wr == 2'd3 ||
           (rd == 2'd1 && ln) || (wr == 2'd1 && ln));
    old  = refm[w];
    e_resp = 0; e_re = 0; e_we = 0;
    e_data = 16'h0; e_wd = 16'h0;
    if (noop) begin
      e_resp = 0;
    end else if (err) begin
      e_resp = 1;
    end else if (rd == 2'd1) begin
      e_re = 1; e_resp = 3; e_data = old;
    end else if (rd == 2'd2) begin
      e_re = 1; e_resp = 3;
      e_data = ln ? (old >> 8) : (old & 16'h00FF);
    end else if (wr == 2'd1) begin
      e_we = 1; e_resp = 2; e_wd = wd;
    end else begin
      e_re = 1; e_we = 3; e_resp = 4;
      e_wd = ln ? {wd[7:0], old[7:0]}
                : {old[15:8], wd[7:0]};
    end
    if (pulse) begin
      e_re = 0; e_we = 0; e_resp = 0;
    end

    n_re = 0; n_we = 0; n_resp = 0;
    c_re = 0; c_we = 0; c_resp = 0;
    both = 0; busy_bad = 0;
    a_re = '0; a_we = '0; d_we = '0;
    r_d = '0; r_e = 1'b0;

    ifc.req_valid     = 1'b1;
    ifc.req_mem_read  = rd;
    ifc.req_mem_write = wr;
    ifc.req_addr      = a;
    ifc.req_wdata     = wd;

    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1;
      if (pulse) rst = (c == 1);
      #1;
      if (ifc.mem_re) begin
        n_re++; c_re = c; a_re = ifc.mem_addr;
      end
      if (ifc.mem_we) begin
        n_we++; c_we = c; a_we = ifc.mem_addr;
        d_we = ifc.mem_wdata;
      end
      if (ifc.mem_re && ifc.mem_we) both++;
      if (ifc.resp_valid) begin
        n_resp++;
        if (c_resp == 0) begin
          c_resp = c;
          r_d = ifc.resp_data;
          r_e = ifc.resp_err;
        end
      end
      if (e_resp != 0 && c <= e_resp && ifc.req_ready)
        busy_bad++;
      if (!noop && !pulse && c_resp == 0) begin
        ifc.req_valid     = 1'($urandom_range(0, 1));
        ifc.req_mem_read  = 2'($urandom_range(0, 3));
        ifc.req_mem_write = 2'($urandom_range(0, 3));
        ifc.req_addr      = 16'($urandom);
        ifc.req_wdata     = 16'($urandom);
      end else begin
        ifc.req_valid = 1'b0;
      end
    end

    chk("resp_cycle", c_resp, e_resp);
    chk("resp_count", n_resp, (e_resp != 0) ? 1 : 0);
    chk("re_cycle", c_re, e_re);
    chk("re_count", n_re, (e_re != 0) ? 1 : 0);
    chk("we_cycle", c_we, e_we);
    chk("we_count", n_we, (e_we != 0) ? 1 : 0);
    chk("re_we_overlap", both, 0);
    chk("ready_busy", busy_bad, 0);
    chk("ready_end", ifc.req_ready, 1'b1);
    if (e_re != 0) chk("re_addr", a_re, w);
    if (e_we != 0) begin
      chk("we_addr", a_we, w);
      chk("we_data", d_we, e_wd);
    end
    if (pulse) begin
      prev_data = '0;
      prev_err  = 1'b0;
    end
    if (e_resp != 0) begin
      chk("resp_data", r_d, e_data);
      chk("resp_err", r_e, err);
      prev_data = e_data;
      prev_err  = err;
    end
    chk("hold_data", ifc.resp_data, prev_data);
    chk("hold_err", ifc.resp_err, prev_err);
    if (e_we != 0) refm[w] = e_wd;
    chk("mem_word", phys[w], refm[w]);
  endtask

  initial begin
    logic [15:0] v;
    logic [1:0] rd, wr;
    logic [15:0] a;
    int sel;

    rst = 1'b1;
    ifc.req_valid     = 1'b0;
    ifc.req_mem_read  = 2'b00;
    ifc.req_mem_write = 2'b00;
    ifc.req_addr      = 16'h0;
    ifc.req_wdata     = 16'h0;
    prev_data = '0;
    prev_err  = 1'b0;
    for (int i = 0; i < 32768; i++) begin
      v = 16'($urandom);
      set_word(15'(i), v);
    end
    set_word(15'd2, 16'h1234);

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_resp_data", ifc.resp_data, 16'h0);
    chk("rst_resp_err", ifc.resp_err, 1'b0);
    chk("rst_mem_addr", ifc.mem_addr, 15'h0);
    chk("rst_mem_wdata", ifc.mem_wdata, 16'h0);
    for (int c = 0; c < 3; c++) begin
      chk("idle_ready", ifc.req_ready, 1'b1);
      chk("idle_resp_valid", ifc.resp_valid, 1'b0);
      chk("idle_re", ifc.mem_re, 1'b0);
      chk("idle_we", ifc.mem_we, 1'b0);
      @(posedge clk);
      #2;
    end

    run_req(2'b01, 2'b00, 16'd4, 16'h0, 1'b0);
    run_req(2'b10, 2'b00, 16'd5, 16'h0, 1'b0);
    run_req(2'b10, 2'b00, 16'd4, 16'h0, 1'b0);
    run_req(2'b00, 2'b10, 16'd4, 16'hABCD, 1'b0);
    chk("sb_lane0_word", phys[2], 16'h12CD);
    set_word(15'd2, 16'h1234);
    run_req(2'b00, 2'b10, 16'd5, 16'hABCD, 1'b0);
    chk("sb_lane1_word", phys[2], 16'hCD34);
    run_req(2'b00, 2'b01, 16'd3, 16'h5555, 1'b0);
    run_req(2'b01, 2'b01, 16'd6, 16'h5555, 1'b0);
    run_req(2'b11, 2'b00, 16'd6, 16'h0, 1'b0);
    run_req(2'b00, 2'b11, 16'd6, 16'h0, 1'b0);
    set_word(15'd4, 16'h0F0F);
    run_req(2'b00, 2'b01, 16'd8, 16'hBEEF, 1'b1);
    chk("abort_word", phys[4], 16'h0F0F);
    run_req(2'b00, 2'b01, 16'd8, 16'hBEEF, 1'b0);
    chk("sw_word", phys[4], 16'hBEEF);
    run_req(2'b00, 2'b00, 16'd8, 16'h1111, 1'b0);
    run_req(2'b01, 2'b00, 16'hFFFF, 16'h0, 1'b0);
    run_req(2'b10, 2'b00, 16'hFFFF, 16'h0, 1'b0);
    run_req(2'b00, 2'b10, 16'hFFFF, 16'h7E7E, 1'b0);
    run_req(2'b01, 2'b00, 16'hFFFE, 16'h0, 1'b0);

    for (int t = 0; t < 150; t++) begin
      sel = $urandom_range(0, 9);
      rd = 2'b00;
      wr = 2'b00;
      case (sel)
        0, 1: rd = 2'b01;
        2, 3: rd = 2'b10;
        4, 5: wr = 2'b01;
        6, 7: wr = 2'b10;
        default: begin
          rd = 2'($urandom_range(0, 3));
          wr = 2'($urandom_range(0, 3));
        end
      endcase
      if ($urandom_range(0, 7) == 0)
        a = 16'hFFFF - 16'($urandom_range(0, 3));
      else
        a = 16'($urandom_range(0, 63));
      run_req(rd, wr, a, 16'($urandom),
              ($urandom_range(0, 19) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
